// File: rtl/stereo_column_feeder.sv
// Raster scanner feeding the stereo SAD matcher: reads KERNEL_WIDTH-tall pixel columns from the
// left/right frame-buffer BRAMs and offers each column pair with a single-cycle valid pulse.
module stereo_column_feeder #(
  parameter int unsigned KERNEL_WIDTH = 3,
  parameter int unsigned H_ACTIVE     = 320,
  parameter int unsigned V_ACTIVE     = 180,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 start_in,
  input  logic                                 busy_in,
  input  logic [7:0]                           left_pixel_in,
  input  logic [7:0]                           right_pixel_in,
  output logic [$clog2(H_ACTIVE*V_ACTIVE)-1:0] addr_out,
  output logic [KERNEL_WIDTH-1:0][7:0]         left_data_out,
  output logic [KERNEL_WIDTH-1:0][7:0]         right_data_out,
  output logic [10:0]                          hcount_out,
  output logic [9:0]                           vcount_out,
  output logic                                 data_valid_out,
  output logic                                 frame_done_out,
  output logic                                 busy_out
);

  localparam int unsigned AW = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int unsigned RW = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
  localparam int unsigned CW = $clog2(KERNEL_WIDTH + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StOffer = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]                       state_q, state_d;
  logic [10:0]                      h_q, h_d;
  logic [9:0]                       v_q, v_d;
  logic [RW-1:0]                    row_q, row_d;
  logic [AW-1:0]                    addr_q, addr_d;
  logic [AW-1:0]                    base_q, base_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [READ_LATENCY-1:0]          pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0][RW-1:0]  pipe_row_q, pipe_row_d;
  logic [KERNEL_WIDTH-1:0][7:0]     stage_l_q, stage_l_d;
  logic [KERNEL_WIDTH-1:0][7:0]     stage_r_q, stage_r_d;
  logic [KERNEL_WIDTH-1:0][7:0]     out_l_q, out_l_d;
  logic [KERNEL_WIDTH-1:0][7:0]     out_r_q, out_r_d;
  logic [10:0]                      hcount_q, hcount_d;
  logic [9:0]                       vcount_q, vcount_d;

  logic          offer;
  logic          cap_vld;
  logic [RW-1:0] cap_row;

  assign offer   = (state_q == StOffer) && !busy_in;
  assign cap_vld = pipe_vld_q[READ_LATENCY-1];
  assign cap_row = pipe_row_q[READ_LATENCY-1];

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    row_d     = row_q;
    addr_d    = addr_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    stage_l_d = stage_l_q;
    stage_r_d = stage_r_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;

    // Tag every issued address with its row so the return lands in the right staging slot.
    pipe_vld_d[0] = (state_q == StRead);
    pipe_row_d[0] = row_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_row_d[i] = pipe_row_q[i-1];
    end

    if (cap_vld) begin
      stage_l_d[cap_row] = left_pixel_in;
      stage_r_d[cap_row] = right_pixel_in;
      cnt_d              = cnt_q + CW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d = StRead;
          h_d     = '0;
          v_d     = '0;
          row_d   = '0;
          addr_d  = '0;
          base_d  = '0;
          cnt_d   = '0;
        end
      end
      StRead: begin
        if (row_q == RW'(KERNEL_WIDTH - 1)) begin
          state_d = StWait;
        end else begin
          row_d  = row_q + RW'(1);
          addr_d = addr_q + AW'(H_ACTIVE);
        end
      end
      StWait: begin
        if (cnt_d == CW'(KERNEL_WIDTH)) begin
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (!busy_in) begin
          out_l_d  = stage_l_q;
          out_r_d  = stage_r_q;
          hcount_d = h_q;
          vcount_d = v_q;
          // base = v*H_ACTIVE + h, so both h+1 and the wrap to (0, v+1) are base+1.
          if (h_q < 11'(H_ACTIVE - 1)) begin
            h_d     = h_q + 11'd1;
            state_d = StRead;
          end else if (v_q < 10'(V_ACTIVE - KERNEL_WIDTH)) begin
            h_d     = '0;
            v_d     = v_q + 10'd1;
            state_d = StRead;
          end else begin
            state_d = StDone;
          end
          if (state_d == StRead) begin
            base_d = base_q + AW'(1);
            addr_d = base_q + AW'(1);
            row_d  = '0;
            cnt_d  = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      h_q        <= '0;
      v_q        <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      pipe_vld_q <= '0;
      pipe_row_q <= '0;
      stage_l_q  <= '0;
      stage_r_q  <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_row_q <= pipe_row_d;
      stage_l_q  <= stage_l_d;
      stage_r_q  <= stage_r_d;
      out_l_q    <= out_l_d;
      out_r_q    <= out_r_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
    end
  end

  // On the valid cycle the staged column is shown directly; otherwise the last offer is held.
  assign data_valid_out = offer;
  assign left_data_out  = offer ? stage_l_q : out_l_q;
  assign right_data_out = offer ? stage_r_q : out_r_q;
  assign hcount_out     = offer ? h_q : hcount_q;
  assign vcount_out     = offer ? v_q : vcount_q;
  assign addr_out       = addr_q;
  assign frame_done_out = (state_q == StDone);
  assign busy_out       = (state_q == StRead) || (state_q == StWait) || (state_q == StOffer);

endmodule
